grid_cursor_rpt: RTL and testbench
==================================

Name: grid_cursor_rpt

Overview:
Parametrised successor of the calculator keypad cursor. It tracks a cursor over a COLS x ROWS key grid and emits the key code under the cursor. It adds press edge detection with hold-to-repeat, selectable wrap or saturate at grid edges, forbidden-zone blocking with a status pulse, and relocation when restriction rises. It sits between the debounced pushbutton inputs and the VGA keypad renderer / calculator input FSM.

Parameters:
COLS, 6, grid columns (>=2)
ROWS, 4, grid rows (>=2)
DIG_COLS, 4, leftmost columns holding digit keys; the remaining columns hold operator keys
RESTR_ROW, 2, first row of the forbidden zone when restriction=1
WRAP, 1, 1 = wrap around at edges; 0 = saturate at edges
REP_DELAY, 25_000_000, hold cycles from press to first repeat step (>=2)
REP_RATE, 5_000_000, cycles between subsequent repeat steps (>=1)
VAL_W, 5, key code width

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low
restriction  in  1  1 = cells with x<DIG_COLS and y>=RESTR_ROW are forbidden
dir_up  in  1  level, debounced; moves y-1
dir_down  in  1  level, debounced; moves y+1
dir_left  in  1  level, debounced; moves x-1
dir_right  in  1  level, debounced; moves x+1
pos_x  out  $clog2(COLS)  cursor column
pos_y  out  $clog2(ROWS)  cursor row
val  out  VAL_W  key code under cursor (combinational from pos)
moved  out  1  one-cycle pulse, cursor changed this cycle
blocked  out  1  one-cycle pulse, step rejected (forbidden target or saturated edge)

Behaviour:
- Reset (rst=0 at posedge): pos=(0,0); moved=0; blocked=0; repeat FSM in IDLE; counter=0; previous-direction register=0.
- Direction valid only when exactly one dir_* is high. Zero or more than one high = no direction: FSM goes to IDLE and no step is issued.
- Repeat FSM states:
  - IDLE: go to DELAY and issue a step when a valid direction is newly present, i.e. a different direction from last cycle or the previous cycle had none.
  - DELAY: counter increments while the same direction is held. At counter==REP_DELAY-1, issue a step, clear the counter, and go to REPEAT.
  - REPEAT: at counter==REP_RATE-1, issue a step and clear the counter.
  - In DELAY or REPEAT, a change of direction behaves as a new press: step, DELAY, counter cleared.
- Steps are issued in the press cycle N, at N+REP_DELAY, then every REP_RATE cycles. pos updates at the clock edge ending the step cycle (1-cycle latency). moved and blocked are registered with pos.
- Step target: x±1 or y±1.
  - WRAP=1: COLS-1 -> 0 and 0 -> COLS-1; same rule for ROWS.
  - WRAP=0: a step past an edge is rejected with blocked=1.
- Forbidden target (restriction=1 and target in zone): pos holds, blocked=1, moved=0. No search past the forbidden cell.
- Relocation: restriction=1 and current pos in zone forces pos=(0,0) on the next edge with moved=1. This overrides any step in the same cycle.
- val:
  - x<DIG_COLS: y*DIG_COLS+x.
  - Otherwise: {1'b1, (x-DIG_COLS)*ROWS+y} in the low bits.
  - Any code not fitting VAL_W, and any unreachable pos: all ones (5'h1F).
  - Default 6x4 map: digits 0x0-0xF; column 4 = SUM 0x10, MUL 0x11, AND 0x12, EXE 0x13; column 5 = SUB 0x14, OR 0x15, CE 0x16, CLR 0x17.
- Counter width: $clog2(max(REP_DELAY,REP_RATE)). The counter saturates and never wraps silently.

Decomposition:
- Package grid_cursor_pkg:
  - dir_t enum {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}
  - rep_state_t enum {IDLE, DELAY, REPEAT}
  - operator key constants (KEY_SUM..KEY_CLR)
  - KEY_NONE = 5'h1F
- Sub-module dir_repeat: one-hot check, edge detect, repeat FSM and counter; outputs step pulse plus dir_t.
- grid_cursor_rpt contains target computation, wrap/saturate, forbidden check, relocation, pos registers and the val map.

Test Plan:
(Bench uses REP_DELAY=4, REP_RATE=2, default grid.)
1. Reset, then a 1-cycle dir_right pulse ×3 -> pos (3,0), val=0x3, moved high 3 times; dir_right again -> (4,0), val=0x10.
2. WRAP=1 at (0,0): dir_left pulse -> (5,0), val=0x14. WRAP=0 at (0,0): dir_left -> stays (0,0), blocked=1 for 1 cycle.
3. dir_down held 12 cycles from (0,0), restriction=0 -> steps at cycles 0, 4, 6, 8, 10; pos_y sequence 1, 2, 3, 0, 1.
4. restriction=1 at (1,1): dir_down -> stays (1,1), blocked=1. Move to (4,1), then dir_down -> (4,2), val=0x12.
5. restriction=0 at (2,3): raise restriction -> next edge pos=(0,0), moved=1. dir_up and dir_left high together -> no movement.
6. dir_right held at pos (2,0) with rst=0 pulsed mid-DELAY -> pos=(0,0), FSM in IDLE; with dir_right still held after reset release, one step at release -> (1,0).

Source files
------------

// File: rtl/grid_cursor_pkg.sv
// grid_cursor_pkg
// Shared types and constants for the grid cursor with hold-to-repeat.
//   dir_t       : decoded direction from the pushbuttons
//   rep_state_t : hold-to-repeat FSM states
//   KEY_*       : operator key codes of the default 6x4 keypad map
//   in_zone     : forbidden-zone membership test for a cell
package grid_cursor_pkg;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rep_state_t;

    localparam logic [4:0] KEY_SUM  = 5'h10;
    localparam logic [4:0] KEY_MUL  = 5'h11;
    localparam logic [4:0] KEY_AND  = 5'h12;
    localparam logic [4:0] KEY_EXE  = 5'h13;
    localparam logic [4:0] KEY_SUB  = 5'h14;
    localparam logic [4:0] KEY_OR   = 5'h15;
    localparam logic [4:0] KEY_CE   = 5'h16;
    localparam logic [4:0] KEY_CLR  = 5'h17;
    localparam logic [4:0] KEY_NONE = 5'h1F;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The forbidden zone is the lower-left block of digit keys.
    function automatic logic in_zone(input logic restriction, input int x, input int y,
                                     input int dig_cols, input int restr_row);
        return restriction && (x < dig_cols) && (y >= restr_row);
    endfunction

endpackage

// File: rtl/dir_repeat.sv
// dir_repeat
// Turns four debounced direction levels into single step requests with
// hold-to-repeat: one step on press, one after REP_DELAY cycles of holding,
// then one every REP_RATE cycles.
// Ports:
//   clk, rst                       : clock, synchronous active-low reset
//   dir_up/down/left/right         : debounced direction levels
//   step                           : one-cycle request to move the cursor
//   dir                            : decoded direction (DIR_NONE unless exactly one is high)
//
// state  | meaning
// IDLE   | no direction held, waiting for a new press
// DELAY  | direction held, counting towards the first repeat
// REPEAT | direction held past the delay, stepping every REP_RATE cycles
module dir_repeat
    import grid_cursor_pkg::*;
#(
    parameter int REP_DELAY = 25_000_000,
    parameter int REP_RATE  = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic dir_up,
    input  logic dir_down,
    input  logic dir_left,
    input  logic dir_right,
    output logic step,
    output dir_t dir
);

    localparam int CNT_W = $clog2(max_int(REP_DELAY, REP_RATE));
    localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_TC  = CNT_W'(REP_RATE - 1);

    rep_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    dir_t             prev_dir, dir_cur;
    logic             new_press;
    logic             tc_hit;

    always_comb begin
        case ({dir_up, dir_down, dir_left, dir_right})
            4'b1000: dir_cur = DIR_UP;
            4'b0100: dir_cur = DIR_DOWN;
            4'b0010: dir_cur = DIR_LEFT;
            4'b0001: dir_cur = DIR_RIGHT;
            default: dir_cur = DIR_NONE;
        endcase
    end

    // A switch from one direction straight to another counts as a fresh press.
    assign new_press = (dir_cur != DIR_NONE) && (dir_cur != prev_dir);

    always_comb begin
        case (state)
            DELAY:   tc_hit = (cnt == DELAY_TC);
            REPEAT:  tc_hit = (cnt == RATE_TC);
            default: tc_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            prev_dir <= DIR_NONE;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            prev_dir <= dir_cur;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (dir_cur == DIR_NONE) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (new_press) begin
            state_nxt = DELAY;
            cnt_nxt   = '0;
        end else if (state != IDLE) begin
            if (tc_hit) begin
                state_nxt = REPEAT;
                cnt_nxt   = '0;
            end else if (cnt != '1) begin
                // Saturate rather than wrap if the terminal count were ever missed.
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        step = (dir_cur != DIR_NONE) && (new_press || tc_hit);
        dir  = dir_cur;
    end

endmodule

// File: rtl/grid_cursor_rpt.sv
// grid_cursor_rpt
// Cursor over a COLS x ROWS keypad grid with hold-to-repeat, wrap or
// saturate at the edges, a forbidden zone of digit keys and relocation to
// (0,0) when the cursor finds itself inside that zone.
// Ports:
//   clk, rst              : clock, synchronous active-low reset
//   restriction           : enables the forbidden zone
//   dir_up/down/left/right: debounced direction levels
//   pos_x, pos_y          : cursor position
//   val                   : key code under the cursor
//   moved                 : one-cycle pulse, position changed
//   blocked               : one-cycle pulse, a step was rejected
module grid_cursor_rpt
    import grid_cursor_pkg::*;
#(
    parameter int COLS      = 6,
    parameter int ROWS      = 4,
    parameter int DIG_COLS  = 4,
    parameter int RESTR_ROW = 2,
    parameter int WRAP      = 1,
    parameter int REP_DELAY = 25_000_000,
    parameter int REP_RATE  = 5_000_000,
    parameter int VAL_W     = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     restriction,
    input  logic                     dir_up,
    input  logic                     dir_down,
    input  logic                     dir_left,
    input  logic                     dir_right,
    output logic [$clog2(COLS)-1:0]  pos_x,
    output logic [$clog2(ROWS)-1:0]  pos_y,
    output logic [VAL_W-1:0]         val,
    output logic                     moved,
    output logic                     blocked
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    logic          step;
    dir_t          dir;
    logic [XW-1:0] tgt_x;
    logic [YW-1:0] tgt_y;
    logic          edge_hit;
    logic          tgt_forbidden;
    logic          cur_forbidden;
    int            ix, iy, code;

    dir_repeat #(
        .REP_DELAY (REP_DELAY),
        .REP_RATE  (REP_RATE)
    ) u_dir_repeat (
        .clk       (clk),
        .rst       (rst),
        .dir_up    (dir_up),
        .dir_down  (dir_down),
        .dir_left  (dir_left),
        .dir_right (dir_right),
        .step      (step),
        .dir       (dir)
    );

    always_comb begin
        tgt_x    = pos_x;
        tgt_y    = pos_y;
        edge_hit = 1'b0;
        case (dir)
            DIR_UP: begin
                if (pos_y == '0) begin
                    if (WRAP != 0) tgt_y = Y_LAST;
                    else           edge_hit = 1'b1;
                end else begin
                    tgt_y = pos_y - YW'(1);
                end
            end
            DIR_DOWN: begin
                if (pos_y == Y_LAST) begin
                    if (WRAP != 0) tgt_y = '0;
                    else           edge_hit = 1'b1;
                end else begin
                    tgt_y = pos_y + YW'(1);
                end
            end
            DIR_LEFT: begin
                if (pos_x == '0) begin
                    if (WRAP != 0) tgt_x = X_LAST;
                    else           edge_hit = 1'b1;
                end else begin
                    tgt_x = pos_x - XW'(1);
                end
            end
            DIR_RIGHT: begin
                if (pos_x == X_LAST) begin
                    if (WRAP != 0) tgt_x = '0;
                    else           edge_hit = 1'b1;
                end else begin
                    tgt_x = pos_x + XW'(1);
                end
            end
            default: ;
        endcase
    end

    assign tgt_forbidden = in_zone(restriction, int'(tgt_x), int'(tgt_y), DIG_COLS, RESTR_ROW);
    assign cur_forbidden = in_zone(restriction, int'(pos_x), int'(pos_y), DIG_COLS, RESTR_ROW);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pos_x   <= '0;
            pos_y   <= '0;
            moved   <= 1'b0;
            blocked <= 1'b0;
        end else if (cur_forbidden) begin
            // Relocation wins over any step requested in the same cycle.
            pos_x   <= '0;
            pos_y   <= '0;
            moved   <= (pos_x != '0) || (pos_y != '0);
            blocked <= 1'b0;
        end else if (step) begin
            if (edge_hit || tgt_forbidden) begin
                moved   <= 1'b0;
                blocked <= 1'b1;
            end else begin
                pos_x   <= tgt_x;
                pos_y   <= tgt_y;
                moved   <= 1'b1;
                blocked <= 1'b0;
            end
        end else begin
            moved   <= 1'b0;
            blocked <= 1'b0;
        end
    end

    // Digit columns count row-major; operator columns count column-major
    // with the top bit set. Codes that do not fit fall back to all ones.
    always_comb begin
        ix   = int'(pos_x);
        iy   = int'(pos_y);
        code = 0;
        val  = '1;
        if (ix < COLS && iy < ROWS) begin
            if (ix < DIG_COLS) begin
                code = iy * DIG_COLS + ix;
                if (code < (1 << VAL_W)) val = VAL_W'(code);
            end else begin
                code = (ix - DIG_COLS) * ROWS + iy;
                if (code < (1 << (VAL_W - 1)))
                    val = VAL_W'(code) | (VAL_W'(1) << (VAL_W - 1));
            end
        end
    end

endmodule

// File: tb/tb_grid_cursor_rpt.sv
module tb_grid_cursor_rpt;

    localparam int D = 4;
    localparam int R = 2;
    localparam logic [3:0] NONE  = 4'b0000;
    localparam logic [3:0] UP    = 4'b1000;
    localparam logic [3:0] DOWN  = 4'b0100;
    localparam logic [3:0] LEFT  = 4'b0010;
    localparam logic [3:0] RIGHT = 4'b0001;

    typedef struct packed {
        logic [2:0] x;
        logic [1:0] y;
        logic [4:0] v;
        logic       mv;
        logic       bl;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic restriction = 1'b0;
    logic dir_up = 1'b0, dir_down = 1'b0, dir_left = 1'b0, dir_right = 1'b0;

    logic [2:0] pos_x, s_pos_x;
    logic [1:0] pos_y, s_pos_y;
    logic [4:0] val, s_val;
    logic       moved, blocked, s_moved, s_blocked;

    obs_t obs_main, obs_sat, exp_o;
    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    assign obs_main = {pos_x, pos_y, val, moved, blocked};
    assign obs_sat  = {s_pos_x, s_pos_y, s_val, s_moved, s_blocked};

    always #5 clk = ~clk;

    grid_cursor_rpt #(.WRAP(1), .REP_DELAY(D), .REP_RATE(R)) dut (
        .clk(clk), .rst(rst), .restriction(restriction),
        .dir_up(dir_up), .dir_down(dir_down), .dir_left(dir_left), .dir_right(dir_right),
        .pos_x(pos_x), .pos_y(pos_y), .val(val), .moved(moved), .blocked(blocked)
    );

    grid_cursor_rpt #(.WRAP(0), .REP_DELAY(D), .REP_RATE(R)) dut_sat (
        .clk(clk), .rst(rst), .restriction(restriction),
        .dir_up(dir_up), .dir_down(dir_down), .dir_left(dir_left), .dir_right(dir_right),
        .pos_x(s_pos_x), .pos_y(s_pos_y), .val(s_val), .moved(s_moved), .blocked(s_blocked)
    );

    // Default 6x4 keypad map: digits row-major, then SUM MUL AND EXE / SUB OR CE CLR.
    function automatic logic [4:0] exp_val(input int x, input int y);
        if (x < 4)       return 5'(y * 4 + x);
        else if (x == 4) return 5'h10 + 5'(y);
        else             return 5'h14 + 5'(y);
    endfunction

    function automatic obs_t mk(input int x, input int y, input logic mv, input logic bl);
        obs_t o;
        o.x  = 3'(x);
        o.y  = 2'(y);
        o.v  = exp_val(x, y);
        o.mv = mv;
        o.bl = bl;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("(%0d,%0d) val=%h moved=%b blocked=%b", o.x, o.y, o.v, o.mv, o.bl);
    endfunction

    task automatic drive(input logic [3:0] d, input logic r);
        {dir_up, dir_down, dir_left, dir_right} = d;
        restriction = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(NONE, 1'b0);
        drive(NONE, 1'b0);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        exp_q.push_back(mk(0, 0, 1'b0, 1'b0));
        exp_q.push_back(mk(0, 0, 1'b0, 1'b0));
        exp_o = exp_q.pop_front();
        checks++;
        if (obs_main !== exp_o) begin
            errors++;
            $display("FAIL reset_wrap: got %s want %s", fmt(obs_main), fmt(exp_o));
        end
        exp_o = exp_q.pop_front();
        checks++;
        if (obs_sat !== exp_o) begin
            errors++;
            $display("FAIL reset_sat: got %s want %s", fmt(obs_sat), fmt(exp_o));
        end
    endtask

    task automatic test_right_steps();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(mk(i, 0, 1'b1, 1'b0));
            drive(RIGHT, 1'b0);
            exp_o = exp_q.pop_front();
            checks++;
            if (obs_main !== exp_o) begin
                errors++;
                $display("FAIL right_press%0d: got %s want %s", i, fmt(obs_main), fmt(exp_o));
            end
            exp_q.push_back(mk(i, 0, 1'b0, 1'b0));
            drive(NONE, 1'b0);
            exp_o = exp_q.pop_front();
            checks++;
            if (obs_main !== exp_o) begin
                errors++;
                $display("FAIL right_release%0d: got %s want %s", i, fmt(obs_main), fmt(exp_o));
            end
        end
    endtask

    task automatic test_wrap_saturate();
        do_reset();
        exp_q.push_back(mk(5, 0, 1'b1, 1'b0));
        exp_q.push_back(mk(0, 0, 1'b0, 1'b1));
        drive(LEFT, 1'b0);
        exp_o = exp_q.pop_front();
        checks++;
        if (obs_main !== exp_o) begin
            errors++;
            $display("FAIL wrap_left: got %s want %s", fmt(obs_main), fmt(exp_o));
        end
        exp_o = exp_q.pop_front();
        checks++;
        if (obs_sat !== exp_o) begin
            errors++;
            $display("FAIL sat_left: got %s want %s", fmt(obs_sat), fmt(exp_o));
        end
        exp_q.push_back(mk(5, 0, 1'b0, 1'b0));
        exp_q.push_back(mk(0, 0, 1'b0, 1'b0));
        drive(NONE, 1'b0);
        exp_o = exp_q.pop_front();
        checks++;
        if (obs_main !== exp_o) begin
            errors++;
            $display("FAIL wrap_release: got %s want %s", fmt(obs_main), fmt(exp_o));
        end
        exp_o = exp_q.pop_front();
        checks++;
        if (obs_sat !== exp_o) begin
            errors++;
            $display("FAIL sat_blocked_pulse: got %s want %s", fmt(obs_sat), fmt(exp_o));
        end
    endtask

    task automatic test_hold_repeat();
        int   y;
        logic st;
        y = 0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            st = (k == 0) || (k >= D && ((k - D) % R) == 0);
            if (st) y = (y + 1) % 4;
            exp_q.push_back(mk(0, y, st, 1'b0));
            drive(DOWN, 1'b0);
            exp_o = exp_q.pop_front();
            checks++;
            if (obs_main !== exp_o) begin
                errors++;
                $display("FAIL hold_down_cyc%0d: got %s want %s", k, fmt(obs_main), fmt(exp_o));
            end
        end
        drive(NONE, 1'b0);
    endtask

    task automatic test_forbidden();
        logic [3:0] dt [7] = '{RIGHT, DOWN, DOWN, RIGHT, RIGHT, RIGHT, DOWN};
        logic       rt [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int         xt [7] = '{1, 1, 1, 2, 3, 4, 4};
        int         yt [7] = '{0, 1, 1, 1, 1, 1, 2};
        logic       bt [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(mk(xt[i], yt[i], ~bt[i], bt[i]));
            drive(dt[i], rt[i]);
            exp_o = exp_q.pop_front();
            checks++;
            if (obs_main !== exp_o) begin
                errors++;
                $display("FAIL forbid_step%0d: got %s want %s", i, fmt(obs_main), fmt(exp_o));
            end
            exp_q.push_back(mk(xt[i], yt[i], 1'b0, 1'b0));
            drive(NONE, rt[i]);
            exp_o = exp_q.pop_front();
            checks++;
            if (obs_main !== exp_o) begin
                errors++;
                $display("FAIL forbid_release%0d: got %s want %s", i, fmt(obs_main), fmt(exp_o));
            end
        end
    endtask

    task automatic test_relocate();
        logic [3:0] dt [3] = '{RIGHT, RIGHT, UP};
        int         xt [3] = '{1, 2, 2};
        int         yt [3] = '{0, 0, 3};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(xt[i], yt[i], 1'b1, 1'b0));
            drive(dt[i], 1'b0);
            exp_o = exp_q.pop_front();
            checks++;
            if (obs_main !== exp_o) begin
                errors++;
                $display("FAIL reloc_setup%0d: got %s want %s", i, fmt(obs_main), fmt(exp_o));
            end
            drive(NONE, 1'b0);
        end
        // Restriction rises together with a fresh press: relocation must win.
        exp_q.push_back(mk(0, 0, 1'b1, 1'b0));
        drive(RIGHT, 1'b1);
        exp_o = exp_q.pop_front();
        checks++;
        if (obs_main !== exp_o) begin
            errors++;
            $display("FAIL reloc_jump: got %s want %s", fmt(obs_main), fmt(exp_o));
        end
        exp_q.push_back(mk(0, 0, 1'b0, 1'b0));
        drive(NONE, 1'b1);
        exp_o = exp_q.pop_front();
        checks++;
        if (obs_main !== exp_o) begin
            errors++;
            $display("FAIL reloc_settle: got %s want %s", fmt(obs_main), fmt(exp_o));
        end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(0, 0, 1'b0, 1'b0));
            drive(UP | LEFT, 1'b0);
            exp_o = exp_q.pop_front();
            checks++;
            if (obs_main !== exp_o) begin
                errors++;
                $display("FAIL two_dirs_cyc%0d: got %s want %s", k, fmt(obs_main), fmt(exp_o));
            end
        end
        drive(NONE, 1'b0);
    endtask

    task automatic test_reset_mid_delay();
        do_reset();
        drive(RIGHT, 1'b0);
        drive(NONE, 1'b0);
        drive(RIGHT, 1'b0);
        drive(NONE, 1'b0);
        exp_q.push_back(mk(3, 0, 1'b1, 1'b0));
        exp_q.push_back(mk(3, 0, 1'b0, 1'b0));
        exp_q.push_back(mk(0, 0, 1'b0, 1'b0));
        exp_q.push_back(mk(1, 0, 1'b1, 1'b0));
        exp_q.push_back(mk(1, 0, 1'b0, 1'b0));
        exp_q.push_back(mk(1, 0, 1'b0, 1'b0));
        exp_q.push_back(mk(1, 0, 1'b0, 1'b0));
        exp_q.push_back(mk(2, 0, 1'b1, 1'b0));
        for (int k = 0; k < 8; k++) begin
            rst = (k == 2) ? 1'b0 : 1'b1;
            drive(RIGHT, 1'b0);
            exp_o = exp_q.pop_front();
            checks++;
            if (obs_main !== exp_o) begin
                errors++;
                $display("FAIL rst_mid_delay_cyc%0d: got %s want %s", k, fmt(obs_main), fmt(exp_o));
            end
        end
        rst = 1'b1;
        drive(NONE, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_right_steps();
        test_wrap_saturate();
        test_hold_repeat();
        test_forbidden();
        test_relocate();
        test_reset_mid_delay();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
